cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, bitstream word width.
REQ-002 SHALL have parameter CHAIN_BITS, default 17, total config-chain length in bits.
REQ-003 SHALL have parameter RST_CYCLES, default 2, fabric-reset pulse length in clk cycles.
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load.
- word_valid  in  1  word available.
- word_data  in  WORD_WIDTH  bitstream word, MSB shifted first.
- word_last  in  1  final word of the stream.
- word_ready  out  1  word accepted when valid&&ready.
- config_data_out  out  1  serial bit to the chain head config_data_in.
- config_en  out  1  chain shift enable.
- le_nrst  out  1  fabric reset, active-low.
- done  out  1  load complete.
- error  out  1  load failed.

Function
REQ-005 SHALL implement states IDLE, LOAD, FRST, DONE, ERR.
REQ-006 SHALL leave IDLE, DONE or ERR for LOAD on start=1, clearing the bit counter, done and error.
REQ-007 SHALL assert word_ready only in LOAD with the shift register empty, giving one bubble cycle per word.
REQ-008 SHALL shift an accepted word (cycle N) out MSB-first on cycles N+1..N+k, one bit per cycle, where k=min(WORD_WIDTH, CHAIN_BITS-count).
REQ-009 SHALL discard the unused LSBs of a partial final word.
REQ-010 SHALL hold config_en high exactly on cycles presenting a valid chain bit, and low otherwise.
REQ-011 SHALL hold config_data_out at 0 whenever config_en=0.
REQ-012 SHALL enter ERR (error=1) when word_last arrives with count+k<CHAIN_BITS, i.e. too few bits.
REQ-013 SHALL enter ERR when a word is accepted after count=CHAIN_BITS without word_last, i.e. too many words.
REQ-014 SHALL keep le_nrst=0 through LOAD and ERR, so the fabric is never released on a failed load.
REQ-015 SHALL, after the last chain bit, drive le_nrst=0 for RST_CYCLES cycles in FRST, then enter DONE with le_nrst=1 and done=1.
REQ-016 SHALL ignore start while in LOAD or FRST.

Reset
REQ-017 SHALL, while rst=1, force: state IDLE, counter 0, word_ready=0, config_en=0, config_data_out=0, le_nrst=0, done=0, error=0.
REQ-018 SHALL, on rst mid-load, abandon the load; partially shifted chain contents are undefined and require a full reload.

Configuration
REQ-019 SHALL, with CFG_LOADER_CRC_EN defined, expect one extra word after the CHAIN_BITS data bits, carrying word_last, whose low 8 bits equal CRC-8 (poly 0x07, init 0x00) over the shifted bits MSB-first.
REQ-020 SHALL, with CFG_LOADER_CRC_EN defined, enter ERR on CRC mismatch instead of FRST, and count the CRC word toward the REQ-012/013 framing checks (word_last belongs on the CRC word).
REQ-021 SHALL, without CFG_LOADER_CRC_EN, expect no CRC word and contain no CRC logic.

Structure
REQ-022 SHALL take the state enum type and the CRC polynomial constant from shared package fpga_cfg_pkg.
REQ-023 SHALL place the CRC in sub-module cfg_crc8 (serial, one bit per config_en cycle), instantiated only under CFG_LOADER_CRC_EN.

Verification
REQ-024 SHALL cover a combinational-XOR load: start, words 0x34CB then 0x0000 with last -> config_en high 17 cycles, serial stream 0_0110100110010110, le_nrst low 2 cycles then high, done=1.
REQ-025 SHALL cover a registered-mode load: words 0x8000, 0x8000+last -> stream 1 then 15 zeros then 1, done=1, downstream LE mode bit=1.
REQ-026 SHALL cover a short stream: single word 0x1234 with last -> error=1, le_nrst stays 0, done=0.
REQ-027 SHALL cover back-pressure: word_valid held with gaps -> word_ready high only when empty, no bit lost or duplicated, 17 total config_en cycles.
REQ-028 SHALL cover rst asserted on the 9th shift cycle -> all outputs at reset values immediately; a subsequent full load completes with done=1.
REQ-029 SHALL cover, under CFG_LOADER_CRC_EN, REQ-024 followed by a correct CRC word -> done=1, and a CRC word with one flipped bit -> error=1, le_nrst=0.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader slice.
// Pure declarations: no timing and no flow control of its own.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FRST = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } cfg_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 (MSB-first, init 0) over the bits presented on the config chain.
// Updates on the clock after each en cycle; no backpressure, follows the shifter.
module cfg_crc8
   import fpga_cfg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);

   logic fb;

   assign fb = crc[7] ^ din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '0;
      end else if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
   end

endmodule

// File: rtl/cfg_loader.sv
// Streams bitstream words MSB-first into the config chain, then pulses fabric reset; one bit/cycle.
// word_ready only while the shifter is empty (one bubble per word); CFG_LOADER_CRC_EN adds a trailing CRC-8 word.
module cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int CHAIN_BITS = 17,
   parameter int RST_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  word_valid,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_last,
   output logic                  word_ready,
   output logic                  config_data_out,
   output logic                  config_en,
   output logic                  le_nrst,
   output logic                  done,
   output logic                  error
);

   localparam int MAXB = (CHAIN_BITS > WORD_WIDTH) ? CHAIN_BITS : WORD_WIDTH;
   localparam int CW   = $clog2(MAXB + 1);
   localparam int RW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [CW-1:0] CHAIN_N  = CW'(CHAIN_BITS);
   localparam logic [CW-1:0] WORD_N   = CW'(WORD_WIDTH);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   cfg_state_t            state;
   logic [WORD_WIDTH-1:0] sh;
   logic [CW-1:0]         sh_cnt;
   logic [CW-1:0]         count;
   logic [CW-1:0]         rem;
   logic [CW-1:0]         k;
   logic [RW-1:0]         rst_cnt;
   logic                  launch;
   logic                  accept;
   logic                  shifting;
   logic                  chain_full;
   logic                  load_err;

   assign launch     = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign shifting   = (state == ST_LOAD) && (sh_cnt != '0);
   assign word_ready = (state == ST_LOAD) && (sh_cnt == '0);
   assign accept     = word_valid && word_ready;
   assign chain_full = (count == CHAIN_N);
   assign rem        = CHAIN_N - count;
   assign k          = (rem < WORD_N) ? rem : WORD_N;

   assign config_en       = shifting;
   assign config_data_out = shifting & sh[WORD_WIDTH-1];
   assign le_nrst         = (state == ST_DONE);
   assign done            = (state == ST_DONE);
   assign error           = (state == ST_ERR);

`ifdef CFG_LOADER_CRC_EN
   logic [7:0] crc;

   cfg_crc8 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (launch),
      .en  (config_en),
      .din (config_data_out),
      .crc (crc)
   );

   // The trailing word is the only one allowed to carry word_last.
   always_comb begin
      load_err = 1'b0;
      if (chain_full) begin
         load_err = !word_last || (word_data[7:0] != crc);
      end else begin
         load_err = word_last;
      end
   end
`else
   logic last_seen;
   logic final_bit;

   assign final_bit = shifting && (sh_cnt == ONE_C) && (count == CHAIN_N - ONE_C);

   always_comb begin
      load_err = chain_full || (word_last && ((count + k) < CHAIN_N));
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         sh      <= '0;
         sh_cnt  <= '0;
         count   <= '0;
         rst_cnt <= '0;
`ifndef CFG_LOADER_CRC_EN
         last_seen <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (launch) begin
                  state  <= ST_LOAD;
                  count  <= '0;
                  sh_cnt <= '0;
`ifndef CFG_LOADER_CRC_EN
                  last_seen <= 1'b0;
`endif
               end
            end
            ST_LOAD: begin
               if (shifting) begin
                  sh     <= sh << 1;
                  sh_cnt <= sh_cnt - ONE_C;
                  count  <= count + ONE_C;
`ifndef CFG_LOADER_CRC_EN
                  if (final_bit && last_seen) begin
                     state   <= ST_FRST;
                     rst_cnt <= '0;
                  end
`endif
               end else if (accept) begin
                  if (load_err) begin
                     state <= ST_ERR;
`ifdef CFG_LOADER_CRC_EN
                  end else if (chain_full) begin
                     state   <= ST_FRST;
                     rst_cnt <= '0;
`endif
                  end else begin
                     // Unused LSBs of a short final word stay in sh and are never shifted.
                     sh     <= word_data;
                     sh_cnt <= k;
`ifndef CFG_LOADER_CRC_EN
                     last_seen <= word_last;
`endif
                  end
               end
            end
            ST_FRST: begin
               if (rst_cnt == RST_LAST) begin
                  state <= ST_DONE;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed table-driven bench for cfg_loader (16-bit words, 17-bit chain, 2-cycle fabric reset).
module tb_cfg_loader;

   localparam int W  = 16;
   localparam int CB = 17;
   localparam int RC = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         word_valid;
   logic [W-1:0] word_data;
   logic         word_last;
   logic         word_ready;
   logic         config_data_out;
   logic         config_en;
   logic         le_nrst;
   logic         done;
   logic         error;

   cfg_loader #(
      .WORD_WIDTH (W),
      .CHAIN_BITS (CB),
      .RST_CYCLES (RC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .word_valid      (word_valid),
      .word_data       (word_data),
      .word_last       (word_last),
      .word_ready      (word_ready),
      .config_data_out (config_data_out),
      .config_en       (config_en),
      .le_nrst         (le_nrst),
      .done            (done),
      .error           (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Chain-side observer: newest bit lands in cap[0].
   int          en_cnt    = 0;
   int          lo_after  = 0;
   int          viol_data = 0;
   int          viol_rdy  = 0;
   logic [63:0] cap       = '0;

   always @(negedge clk) begin
      if (config_en) begin
         cap      = {cap[62:0], config_data_out};
         en_cnt   = en_cnt + 1;
         lo_after = 0;
      end else begin
         if (config_data_out) viol_data = viol_data + 1;
         if (!le_nrst) lo_after = lo_after + 1;
      end
      if (word_ready && config_en) viol_rdy = viol_rdy + 1;
   end

   typedef struct packed {
      logic [3:0][15:0] w;
      logic [3:0]       lastm;
      logic [2:0]       nw;
      logic [1:0]       crc_mode;
      logic [3:0]       gap;
      logic [16:0]      exp_stream;
      logic [5:0]       exp_bits;
      logic             exp_done;
   } vec_t;

`ifdef CFG_LOADER_CRC_EN
   localparam int   NV        = 5;
   localparam logic LAST_DATA = 1'b0;
`else
   localparam int   NV        = 6;
   localparam logic LAST_DATA = 1'b1;
`endif

   vec_t vecs [NV];

   function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                               input logic [3:0] lastm, input logic [2:0] nw, input logic [1:0] crc_mode,
                               input logic [3:0] gap, input logic [16:0] stream, input logic [5:0] bits,
                               input logic dn);
      vec_t v;
      v.w          = {16'h0000, w2, w1, w0};
      v.lastm      = lastm;
      v.nw         = nw;
      v.crc_mode   = crc_mode;
      v.gap        = gap;
      v.exp_stream = stream;
      v.exp_bits   = bits;
      v.exp_done   = dn;
      return v;
   endfunction

`ifdef CFG_LOADER_CRC_EN
   function automatic logic [7:0] crc8_model(input logic [16:0] s);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 16; i >= 0; i--) begin
         fb = c[7] ^ s[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d, input logic l);
      int b;
      b = 0;
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = d;
      word_last  = l;
      while (!word_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (!word_ready) begin
         checks++;
         errors++;
         $display("FAIL word_ready timeout: word %0h never accepted within 100 cycles", d);
      end
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      word_data  = '0;
      word_last  = 1'b0;
   endtask

   task automatic wait_end();
      int b;
      b = 0;
      @(posedge clk);
      #1;
      while (!done && !error && b < 200) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (!done && !error) begin
         checks++;
         errors++;
         $display("FAIL load end timeout: neither done nor error within 200 cycles");
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          base_en, base_vd, base_vr;
      logic [31:0] mask;
      base_en = en_cnt;
      base_vd = viol_data;
      base_vr = viol_rdy;
      pulse_start();
      for (int i = 0; i < int'(v.nw); i++) begin
         send_word(v.w[i], v.lastm[i]);
         repeat (int'(v.gap)) @(negedge clk);
      end
`ifdef CFG_LOADER_CRC_EN
      if (v.crc_mode != 2'd0)
         send_word({8'h00, crc8_model(v.exp_stream) ^ ((v.crc_mode == 2'd2) ? 8'h04 : 8'h00)}, 1'b1);
`endif
      wait_end();
      mask = (32'd1 << v.exp_bits) - 32'd1;
      check($sformatf("v%0d done", idx), 32'(done), 32'(v.exp_done));
      check($sformatf("v%0d error", idx), 32'(error), 32'(!v.exp_done));
      check($sformatf("v%0d le_nrst", idx), 32'(le_nrst), 32'(v.exp_done));
      check($sformatf("v%0d config_en cycles", idx), 32'(en_cnt - base_en), 32'(v.exp_bits));
      check($sformatf("v%0d stream", idx), cap[31:0] & mask, 32'(v.exp_stream) & mask);
      if (v.exp_done)
         check($sformatf("v%0d fabric reset cycles", idx), 32'(lo_after), 32'(RC));
      check($sformatf("v%0d data while en low", idx), 32'(viol_data - base_vd), 32'd0);
      check($sformatf("v%0d ready while shifting", idx), 32'(viol_rdy - base_vr), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_en;

`ifdef CFG_LOADER_CRC_EN
      vecs[0] = mk(16'h34CB, 16'h0000, 16'h0000, 4'b0000, 3'd2, 2'd1, 4'd0, 17'h06996, 6'd17, 1'b1);
      vecs[1] = mk(16'h34CB, 16'h0000, 16'h0000, 4'b0000, 3'd2, 2'd2, 4'd0, 17'h06996, 6'd17, 1'b0);
      vecs[2] = mk(16'h1234, 16'h0000, 16'h0000, 4'b0001, 3'd1, 2'd0, 4'd0, 17'h00000, 6'd0,  1'b0);
      vecs[3] = mk(16'h8000, 16'h8000, 16'h0000, 4'b0010, 3'd2, 2'd0, 4'd0, 17'h08000, 6'd16, 1'b0);
      vecs[4] = mk(16'hA5F0, 16'hFFFF, 16'h0000, 4'b0000, 3'd2, 2'd1, 4'd3, 17'h14BE1, 6'd17, 1'b1);
`else
      vecs[0] = mk(16'h34CB, 16'h0000, 16'h0000, 4'b0010, 3'd2, 2'd0, 4'd0, 17'h06996, 6'd17, 1'b1);
      vecs[1] = mk(16'h8000, 16'h8000, 16'h0000, 4'b0010, 3'd2, 2'd0, 4'd0, 17'h10001, 6'd17, 1'b1);
      vecs[2] = mk(16'h1234, 16'h0000, 16'h0000, 4'b0001, 3'd1, 2'd0, 4'd0, 17'h00000, 6'd0,  1'b0);
      vecs[3] = mk(16'hA5F0, 16'hFFFF, 16'h0000, 4'b0010, 3'd2, 2'd0, 4'd3, 17'h14BE1, 6'd17, 1'b1);
      vecs[4] = mk(16'h1111, 16'h8000, 16'h0000, 4'b0100, 3'd3, 2'd0, 4'd0, 17'h02223, 6'd17, 1'b0);
      vecs[5] = mk(16'hFFFF, 16'h7FFF, 16'h0000, 4'b0010, 3'd2, 2'd0, 4'd1, 17'h1FFFE, 6'd17, 1'b1);
`endif

      rst        = 1'b1;
      start      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      word_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset word_ready", 32'(word_ready), 32'd0);
      check("reset config_en", 32'(config_en), 32'd0);
      check("reset config_data_out", 32'(config_data_out), 32'd0);
      check("reset le_nrst", 32'(le_nrst), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset error", 32'(error), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Reset on the 9th shift cycle, then a clean reload.
      pulse_start();
      base_en = en_cnt;
      send_word(16'h34CB, 1'b0);
      for (int b = 0; b < 50 && (en_cnt - base_en) < 8; b++) begin
         @(posedge clk);
         #1;
      end
      check("rst9 shifting before reset", 32'(config_en), 32'd1);
      rst = 1'b1;
      #1;
      check("rst9 outputs", {26'd0, word_ready, config_en, config_data_out, le_nrst, done, error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(100, vecs[0]);

      // start pulsed mid-load must not restart the load.
      pulse_start();
      base_en = en_cnt;
      send_word(16'h34CB, 1'b0);
      pulse_start();
      send_word(16'h0000, LAST_DATA);
`ifdef CFG_LOADER_CRC_EN
      send_word({8'h00, crc8_model(17'h06996)}, 1'b1);
`endif
      wait_end();
      check("start ignored done", 32'(done), 32'd1);
      check("start ignored config_en cycles", 32'(en_cnt - base_en), 32'd17);
      check("start ignored stream", {15'd0, cap[16:0]}, 32'h00006996);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
